// File: rtl/status_reg_pkg.sv
// Shared CPU definitions for the processor status (flag) register.
package status_reg_pkg;

    localparam int unsigned FLAG_W = 5;

    // Fixed bit positions of the ALU condition flags
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_P = 4;

    localparam logic [FLAG_W-1:0] STATUS_RST = 5'b00000;

    typedef struct packed {
        logic p;
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;

endpackage : status_reg_pkg

// File: rtl/status_reg.sv
// Processor status register: captures ALU condition flags on ld and holds them.
// The output comes straight from the flops, so flags_in has no combinational path to it.
module status_reg
    import status_reg_pkg::*;
#(
    parameter int unsigned       WIDTH     = FLAG_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(STATUS_RST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] flags_in,
    output logic [WIDTH-1:0] flags_out
);

    logic [WIDTH-1:0] r_flags;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("status_reg: WIDTH must be at least 1");
        end
    endgenerate

    // Reset dominates load; all flag bits load together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= RESET_VAL;
        end else if (ld) begin
            r_flags <= flags_in;
        end
    end

    assign flags_out = r_flags;

endmodule : status_reg

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg: expected flag values are queued as stimulus is driven.
module tb_status_reg;
    import status_reg_pkg::*;

    logic              clk;
    logic              rst;
    logic              ld;
    logic [FLAG_W-1:0] flags_in;
    logic [FLAG_W-1:0] flags_out;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [FLAG_W-1:0] exp_q[$];
    logic [FLAG_W-1:0] model;

    status_reg #(.WIDTH(FLAG_W), .RESET_VAL(STATUS_RST)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .flags_in  (flags_in),
        .flags_out (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [FLAG_W-1:0] got,
                             input logic [FLAG_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [FLAG_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s got=%b exp=<empty scoreboard>", tag, flags_out);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, flags_out, e);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then compare after the rising edge
    task automatic step(input string tag, input logic r, input logic l,
                        input logic [FLAG_W-1:0] f);
        @(negedge clk);
        rst      = r;
        ld       = l;
        flags_in = f;
        if (r) begin
            model = STATUS_RST;
            exp_q.push_back(model);
            #1;
            pop_check({tag, "_async"});
        end
        if (r)       model = STATUS_RST;
        else if (l)  model = f;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ld       = 1'b1;
        flags_in = 5'b01010;
        model    = STATUS_RST;

        #1;
        exp_q.push_back(STATUS_RST);
        pop_check("rst_immediate");

        step("rst_with_ld_0", 1'b1, 1'b1, 5'b01010);
        step("rst_with_ld_1", 1'b1, 1'b1, 5'b01010);

        step("basic_load", 1'b0, 1'b1, 5'b01010);

        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, 5'b10101);
        end
        step("load_after_hold", 1'b0, 1'b1, 5'b10101);

        // Reset pulse strictly between clock edges, released before the next edge
        @(negedge clk);
        ld = 1'b0;
        #2;
        rst   = 1'b1;
        model = STATUS_RST;
        #1;
        exp_q.push_back(model);
        pop_check("midcycle_rst");
        rst = 1'b0;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        pop_check("after_midcycle_rst");
        step("stay_cleared", 1'b0, 1'b0, 5'b11011);

        step("b2b_0", 1'b0, 1'b1, 5'b11111);
        step("b2b_1", 1'b0, 1'b1, 5'b00001);
        step("b2b_2", 1'b0, 1'b1, 5'b10000);

        step("rst_during_hold", 1'b1, 1'b0, 5'b10000);
        step("load_after_rst", 1'b0, 1'b1, 5'b01010);

        for (int i = 0; i < 16; i++) begin
            step("random", 1'b0, 1'($urandom_range(0, 1)), FLAG_W'($urandom));
        end
        step("final_rst", 1'b1, 1'b1, 5'b11111);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_status_reg
